// File: rtl/ccff_chain_loader.sv
// Configuration-chain controller: streams config words LSB-first into a ccff shift chain,
// then optionally recirculates the chain once to compare it against a shadow copy.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 12,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify_en,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned BCNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  ChainLenC = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  LastBitC  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CntOne    = CNT_W'(1);
    localparam logic [BCNT_W-1:0] BufOne    = BCNT_W'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [BCNT_W-1:0]  buf_cnt_q;
    logic [WORD_W-1:0]  buf_q;
    logic [CHAIN_LEN-1:0] shadow_q;
    logic               verify_q;
    logic               cfg_ready_q, head_q, shift_en_q, busy_q, done_q, err_q;

    logic [CNT_W-1:0]   remain;
    logic [BCNT_W-1:0]  nbits;
    logic [WORD_W-1:0]  buf_shr;

    always_comb begin
        remain  = ChainLenC - bit_cnt_q;
        nbits   = (32'(remain) > WORD_W) ? BCNT_W'(WORD_W) : BCNT_W'(remain);
        buf_shr = buf_q >> 1;
    end

    // Outputs are precomputed for the state being entered so they appear registered.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            buf_cnt_q   <= '0;
            buf_q       <= '0;
            shadow_q    <= '0;
            verify_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StLoad;
                        verify_q    <= verify_en;
                        err_q       <= 1'b0;
                        bit_cnt_q   <= '0;
                        buf_cnt_q   <= '0;
                        cfg_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                StLoad: begin
                    if (buf_cnt_q == '0) begin
                        if (cfg_ready_q && cfg_valid) begin
                            buf_q       <= cfg_data;
                            buf_cnt_q   <= nbits;
                            cfg_ready_q <= 1'b0;
                            shift_en_q  <= 1'b1;
                            head_q      <= cfg_data[0];
                        end
                    end else begin
                        shadow_q[bit_cnt_q] <= buf_q[0];
                        buf_q     <= buf_shr;
                        buf_cnt_q <= buf_cnt_q - BufOne;
                        bit_cnt_q <= bit_cnt_q + CntOne;
                        if (buf_cnt_q != BufOne) begin
                            head_q <= buf_shr[0];
                        end else begin
                            shift_en_q <= 1'b0;
                            head_q     <= 1'b0;
                            if (bit_cnt_q == LastBitC) begin
                                if (verify_q) begin
                                    state_q    <= StVerify;
                                    shift_en_q <= 1'b1;
                                    bit_cnt_q  <= '0;
                                end else begin
                                    state_q <= StDone;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                cfg_ready_q <= 1'b1;
                            end
                        end
                    end
                end
                StVerify: begin
                    if (ccff_tail != shadow_q[bit_cnt_q]) err_q <= 1'b1;
                    if (bit_cnt_q == LastBitC) begin
                        state_q    <= StDone;
                        shift_en_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CntOne;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Recirculation must be combinational: a registered copy of tail would lengthen the loop.
    assign ccff_head     = (state_q == StVerify) ? ccff_tail : head_q;
    assign cfg_ready     = cfg_ready_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader driving a behavioural 12-flop chain with an optional
// stuck-at-0 fault on flop 5.
module tb_ccff_chain_loader;

    logic       prog_clk = 1'b0;
    logic       prog_reset, start, verify_en, cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, err;

    logic [11:0] chain;
    logic [11:0] chain_rd;
    logic        stuck;
    logic        clr_mon;
    int          shift_cnt;

    int n_total = 0;
    int n_bad   = 0;

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .start         (start),
        .verify_en     (verify_en),
        .cfg_valid     (cfg_valid),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain: head enters flop 0, tail is flop 11; read bit i is the i-th bit shifted in.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= stuck ? ({chain[10:0], ccff_head} & 12'hFDF)
                                          : {chain[10:0], ccff_head};
    end
    assign ccff_tail = chain[11];

    always_comb begin
        chain_rd = '0;
        for (int i = 0; i < 12; i++) chain_rd[i] = chain[11-i];
    end

    always @(posedge prog_clk) begin
        if (clr_mon) shift_cnt <= 0;
        else if (ccff_shift_en) shift_cnt <= shift_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Runs one start..done operation; cyc counts cycles from LOAD entry until done is seen.
    task automatic run_op(input logic [7:0] w0, input logic [7:0] w1, input logic ver,
                          input int gap, input int sp0, input int sp1, input int snap_at,
                          output int cyc, output logic [11:0] snap, output int extra);
        logic [7:0] words [2];
        int  wi;
        int  gap_left;
        logic hs;
        words[0] = w0;
        words[1] = w1;
        wi = 0;
        gap_left = gap;
        extra = 0;
        snap = '0;
        cyc = 0;
        start = 1'b1; verify_en = ver; clr_mon = 1'b1; cfg_valid = 1'b0;
        tick();
        start = 1'b0; verify_en = 1'b0; clr_mon = 1'b0;
        while (!done && cyc < 200) begin
            start = (cyc == sp0 || cyc == sp1);
            if (wi < 2) begin
                cfg_data = words[wi];
                if (wi == 1 && cfg_ready && gap_left > 0) begin
                    cfg_valid = 1'b0;
                    gap_left--;
                    check("gap_shift_en", 32'(ccff_shift_en), 32'd0);
                end else begin
                    cfg_valid = 1'b1;
                end
            end else begin
                cfg_data  = 8'hFF;
                cfg_valid = (sp0 < 200);
            end
            hs = cfg_valid & cfg_ready;
            tick();
            cyc++;
            if (hs) begin
                if (wi < 2) wi++;
                else extra++;
            end
            if (cyc == snap_at) snap = chain_rd;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        tick();
        cfg_valid = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
    endtask

    int          cyc, extra;
    logic [11:0] snap;

    initial begin
        prog_reset = 1'b1; start = 1'b0; verify_en = 1'b0; cfg_valid = 1'b0;
        cfg_data = '0; stuck = 1'b0; clr_mon = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 32'({cfg_ready, ccff_head, ccff_shift_en, busy, done, err}), 32'd0);
        prog_reset = 1'b0;
        clr_mon = 1'b0;
        tick();

        // 1: plain load, no verify
        run_op(8'hA5, 8'h03, 1'b0, 0, 999, 999, 14, cyc, snap, extra);
        check("t1_cycles", 32'(cyc), 32'd14);
        check("t1_shifts", 32'(shift_cnt), 32'd12);
        check("t1_chain", 32'(chain_rd), 32'h3A5);
        check("t1_err", 32'(err), 32'd0);

        // 2: load plus verify on a healthy chain
        run_op(8'hA5, 8'h03, 1'b1, 0, 999, 999, 14, cyc, snap, extra);
        check("t2_cycles", 32'(cyc), 32'd26);
        check("t2_chain_pre", 32'(snap), 32'h3A5);
        check("t2_chain_post", 32'(chain_rd), 32'h3A5);
        check("t2_shifts", 32'(shift_cnt), 32'd24);
        check("t2_err", 32'(err), 32'd0);

        // 3: stuck-at-0 on flop 5 must raise err, which then survives idle time
        stuck = 1'b1;
        run_op(8'hA5, 8'h03, 1'b1, 0, 999, 999, 14, cyc, snap, extra);
        repeat (3) tick();
        check("t3_err_sticky", 32'(err), 32'd1);
        stuck = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_err_cleared", 32'(err), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;

        // 4: 3-cycle valid gap before the second word
        run_op(8'hA5, 8'h03, 1'b0, 3, 999, 999, 17, cyc, snap, extra);
        check("t4_cycles", 32'(cyc), 32'd17);
        check("t4_shifts", 32'(shift_cnt), 32'd12);
        check("t4_chain", 32'(chain_rd), 32'h3A5);

        // 5: reset on the 6th shift cycle, then a clean reload of a different pattern
        clr_mon = 1'b1; start = 1'b1;
        tick();
        clr_mon = 1'b0; start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'h5A;
        repeat (6) tick();
        check("t5_shifting", 32'(ccff_shift_en), 32'd1);
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
        check("t5_reset_outputs",
              32'({cfg_ready, ccff_head, ccff_shift_en, busy, done, err}), 32'd0);
        check("t5_partial_shifts", 32'(shift_cnt), 32'd6);
        tick();
        check("t5_idle_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        run_op(8'h5A, 8'h0C, 1'b0, 0, 999, 999, 14, cyc, snap, extra);
        check("t5_cycles", 32'(cyc), 32'd14);
        check("t5_chain", 32'(chain_rd), 32'hC5A);

        // 6: stray start pulses and stray valid words must be ignored
        cfg_valid = 1'b1; cfg_data = 8'hFF;
        repeat (3) begin
            tick();
            check("t6_idle_ready", 32'(cfg_ready), 32'd0);
        end
        cfg_valid = 1'b0;
        run_op(8'hA5, 8'h03, 1'b1, 0, 3, 16, 14, cyc, snap, extra);
        check("t6_cycles", 32'(cyc), 32'd26);
        check("t6_extra_words", 32'(extra), 32'd0);
        check("t6_chain", 32'(chain_rd), 32'h3A5);
        check("t6_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
Configuration-chain controller for a routing tile's ccff shift chain (connection-block mux memories chained ccff_head -> ccff_tail). Accepts configuration words over a valid/ready stream and serialises them LSB-first onto ccff_head, one bit per enabled prog_clk cycle, for exactly CHAIN_LEN bits. An optional verify pass then recirculates ccff_tail into ccff_head and compares each bit against a shadow copy, leaving the chain contents unchanged.

Parameters:
CHAIN_LEN, 12, number of config flops in the target chain (tile default: two 3-bit size6 mems plus three 2-bit size2 mems); must be >= 1
WORD_W, 8, width of cfg_data; NWORDS = ceil(CHAIN_LEN/WORD_W)

Ports:
prog_clk  input  1  configuration clock; all state on rising edge
prog_reset  input  1  synchronous, active-high reset
start  input  1  begin a load; sampled only in IDLE
verify_en  input  1  sampled with start; 1 = run VERIFY after LOAD
cfg_valid  input  1  cfg_data valid
cfg_data  input  WORD_W  config word; bit 0 shifted first
cfg_ready  output  1  word accepted when cfg_valid & cfg_ready
ccff_head  output  1  serial bit into chain
ccff_shift_en  output  1  chain flops capture ccff_head on this prog_clk edge
ccff_tail  input  1  serial bit out of chain
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of operation
err  output  1  sticky verify mismatch; cleared on accepted start

Behaviour:
- Reset (synchronous, active-high, prog_clk domain): state=IDLE; cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, err=0; counters and shadow cleared. Reset mid-LOAD/VERIFY aborts immediately; the chain is left partially shifted, with no further shift_en after the reset edge.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE: start=1 -> LOAD. Latch verify_en, clear err, bit_cnt=0, word buffer empty. start is ignored in all other states.
- LOAD:
  - cfg_ready=1 iff buffer empty and bit_cnt < CHAIN_LEN.
  - A handshake loads the buffer with nbits = min(WORD_W, CHAIN_LEN-bit_cnt).
  - While the buffer is non-empty: ccff_shift_en=1 and ccff_head=buffer bit 0. On each such edge: shift buffer right, write shadow[bit_cnt]=ccff_head, bit_cnt++.
  - Bits of the final word beyond CHAIN_LEN are discarded and never shifted.
  - Cost per word: 1 accept cycle + nbits shift cycles (one bubble per word). With cfg_valid held high, LOAD lasts CHAIN_LEN + NWORDS cycles.
  - cfg_valid low stalls with shift_en=0; no timeout.
  - At bit_cnt==CHAIN_LEN with buffer empty: VERIFY if verify_en latched, else DONE.
- VERIFY:
  - CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail (recirculate).
  - Cycle k (0-based) compares ccff_tail with shadow[k]; a mismatch sets err.
  - After CHAIN_LEN cycles the chain holds the original contents. -> DONE.
- DONE: done=1 for exactly one cycle, busy=1; -> IDLE. err holds until the next accepted start.
- Outputs are registered. ccff_head and ccff_shift_en change only on prog_clk edges; the chain samples on the same edge on which shift_en is seen high.
- cfg_valid in IDLE/VERIFY/DONE: not accepted (cfg_ready=0); the word is not consumed.

Test Plan:
1. CHAIN_LEN=12, WORD_W=8, verify_en=0, words 0xA5 then 0x03 with cfg_valid always high -> head sequence 1,0,1,0,0,1,0,1,1,1,0,0; exactly 12 shift_en cycles; done pulses once 14 cycles after LOAD entry; upper 4 bits of the second word are never shifted.
2. Same load with verify_en=1 against a behavioural 12-flop chain model -> 12 recirculate cycles; err=0; chain reads 0x3A5 (bit0 = first shifted) both before and after VERIFY.
3. Verify with a stuck-at-0 fault injected at chain flop 5 -> err=1 after VERIFY and stays 1 through IDLE; the next start clears it.
4. cfg_valid deasserted for 3 cycles between words -> shift_en=0 during the gap; bit order unchanged; total cycles +3.
5. prog_reset asserted on the 6th LOAD shift cycle -> next cycle all outputs 0 and state IDLE; a subsequent start reloads all 12 bits correctly.
6. start pulsed during LOAD and during VERIFY, and cfg_valid high while IDLE -> all ignored; no extra words consumed; cfg_ready stays 0 in IDLE.
